// File: rtl/i2cm_seq.sv
// Transaction sequencer in front of the I2C byte engine: round-robin arbitration between
// two requesters and expansion of register write/read transactions into byte commands.
//
// state  | meaning
// IDLE   | no owner, arbitrate on req
// GRANT  | owner granted, request fields latched
// START  | START condition
// DEVW   | WRITE {dev,0}
// REGA   | WRITE register sub-address
// WDATA  | WRITE payload bytes (stalls on wr_valid)
// RSTART | repeated START before the read phase
// DEVR   | WRITE {dev,1}
// RDATA  | READ payload bytes, NACK on the last one
// STOP   | STOP condition
// DONE   | done pulse with status, gnt released next cycle
module i2cm_seq #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  req_rd,
    input  logic [13:0] req_dev,
    input  logic [15:0] req_reg,
    input  logic [7:0]  req_len,
    output logic [1:0]  gnt,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic [1:0]  status,
    output logic [4:0]  cmds,
    output logic [7:0]  tbyte,
    input  logic [4:0]  cdone,
    input  logic        rxack,
    input  logic [7:0]  rbyte,
    input  logic        error
);

    localparam logic [4:0]  C_START  = 5'b00001;
    localparam logic [4:0]  C_WRITE  = 5'b00010;
    localparam logic [4:0]  C_READ   = 5'b00100;
    localparam logic [4:0]  C_STOP   = 5'b01000;
    localparam logic [4:0]  C_TXACK  = 5'b10000;
    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_GRANT, S_START, S_DEVW, S_REGA, S_WDATA,
        S_RSTART, S_DEVR, S_RDATA, S_STOP, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        rd_q, rd_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  cmds_q, cmds_d;
    logic [7:0]  tbyte_q, tbyte_d;
    logic [15:0] tmr_q, tmr_d;
    logic        nack_q, nack_d;
    logic [1:0]  status_q, status_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        issue, sel, waiting, match, tmo;

    // a command is outstanding exactly while cmds is non-zero
    assign waiting = (cmds_q != 5'b00000);
    assign match   = ((cdone & cmds_q & 5'b01111) != 5'b00000);
    assign tmo     = waiting && (tmr_q == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 2'b00;
            last_q     <= 1'b1;
            rd_q       <= 1'b0;
            dev_q      <= 7'd0;
            reg_q      <= 8'd0;
            cnt_q      <= 4'd0;
            cmds_q     <= 5'd0;
            tbyte_q    <= 8'd0;
            tmr_q      <= 16'd0;
            nack_q     <= 1'b0;
            status_q   <= 2'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            rd_q       <= rd_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            cnt_q      <= cnt_d;
            cmds_q     <= cmds_d;
            tbyte_q    <= tbyte_d;
            tmr_q      <= tmr_d;
            nack_q     <= nack_d;
            status_q   <= status_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        rd_d       = rd_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;
        cmds_d     = cmds_q;
        tbyte_d    = tbyte_q;
        nack_d     = nack_q;
        status_d   = status_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_ready   = 1'b0;
        issue      = 1'b0;
        sel        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    sel     = (req == 2'b11) ? ~last_q : req[1];
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    last_d  = sel;
                    rd_d    = req_rd[sel];
                    dev_d   = sel ? req_dev[13:7] : req_dev[6:0];
                    reg_d   = sel ? req_reg[15:8] : req_reg[7:0];
                    cnt_d   = sel ? req_len[7:4]  : req_len[3:0];
                    nack_d  = 1'b0;
                    state_d = S_GRANT;
                end
            end
            S_DONE: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                if (error) begin
                    cmds_d   = 5'd0;
                    status_d = 2'd2;
                    state_d  = S_DONE;
                end else if (waiting) begin
                    if (tmo) begin
                        cmds_d   = 5'd0;
                        status_d = 2'd3;
                        state_d  = S_DONE;
                    end else if (match) begin
                        cmds_d = 5'd0;
                        unique case (state_q)
                            S_START:  state_d = S_DEVW;
                            S_RSTART: state_d = S_DEVR;
                            S_DEVW, S_REGA, S_DEVR: begin
                                if (rxack) begin
                                    nack_d  = 1'b1;
                                    state_d = S_STOP;
                                end else if (state_q == S_DEVW) begin
                                    state_d = S_REGA;
                                end else if (state_q == S_DEVR) begin
                                    state_d = S_RDATA;
                                end else begin
                                    state_d = rd_q ? S_RSTART : S_WDATA;
                                end
                            end
                            S_WDATA: begin
                                if (rxack) begin
                                    nack_d  = 1'b1;
                                    state_d = S_STOP;
                                end else if (cnt_q == 4'd0) begin
                                    state_d = S_STOP;
                                end else begin
                                    cnt_d = cnt_q - 4'd1;
                                end
                            end
                            S_RDATA: begin
                                rd_valid_d = 1'b1;
                                rd_data_d  = rbyte;
                                if (cnt_q == 4'd0) state_d = S_STOP;
                                else               cnt_d = cnt_q - 4'd1;
                            end
                            S_STOP: begin
                                status_d = nack_q ? 2'd1 : 2'd0;
                                state_d  = S_DONE;
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    unique case (state_q)
                        S_GRANT: state_d = S_START;
                        S_START, S_RSTART: begin
                            cmds_d = C_START;
                            issue  = 1'b1;
                        end
                        S_DEVW: begin
                            cmds_d  = C_WRITE;
                            tbyte_d = {dev_q, 1'b0};
                            issue   = 1'b1;
                        end
                        S_REGA: begin
                            cmds_d  = C_WRITE;
                            tbyte_d = reg_q;
                            issue   = 1'b1;
                        end
                        S_WDATA: begin
                            if (wr_valid) begin
                                wr_ready = 1'b1;
                                cmds_d   = C_WRITE;
                                tbyte_d  = wr_data;
                                issue    = 1'b1;
                            end
                        end
                        S_DEVR: begin
                            cmds_d  = C_WRITE;
                            tbyte_d = {dev_q, 1'b1};
                            issue   = 1'b1;
                        end
                        S_RDATA: begin
                            cmds_d = (cnt_q == 4'd0) ? (C_READ | C_TXACK) : C_READ;
                            issue  = 1'b1;
                        end
                        S_STOP: begin
                            cmds_d = C_STOP;
                            issue  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // timeout down-counter: loaded on issue, decremented only while a command is outstanding
    always_comb begin
        if (issue)        tmr_d = TMR_LOAD;
        else if (waiting) tmr_d = tmr_q - 16'd1;
        else              tmr_d = tmr_q;
    end

    assign gnt      = gnt_q;
    assign cmds     = cmds_q;
    assign tbyte    = tbyte_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign status   = status_q;
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_i2cm_seq.sv
// Directed bench for i2cm_seq: engine model, requester models and scoreboard queues
// for commands, read bytes and completions.
module tb_i2cm_seq;
   localparam int ENG_LAT = 2;
   localparam logic [4:0] C_ST = 5'b00001, C_WR = 5'b00010, C_RD = 5'b00100,
                          C_SP = 5'b01000, C_TX = 5'b10000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = 2'b00, req_rd = 2'b00;
   logic [13:0] req_dev = '0;
   logic [15:0] req_reg = '0;
   logic [7:0]  req_len = '0;
   logic [1:0]  gnt;
   logic [7:0]  wr_data = 8'h00;
   logic        wr_valid = 1'b0, wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid, done;
   logic [1:0]  status;
   logic [4:0]  cmds;
   logic [7:0]  tbyte;
   logic [4:0]  cdone = '0;
   logic        rxack = 1'b0;
   logic [7:0]  rbyte = 8'h00;
   logic        error = 1'b0;

   always #5 clk = ~clk;

   i2cm_seq #(.TIMEOUT(20)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_rd(req_rd), .req_dev(req_dev),
      .req_reg(req_reg), .req_len(req_len), .gnt(gnt), .wr_data(wr_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .status(status), .cmds(cmds), .tbyte(tbyte), .cdone(cdone),
      .rxack(rxack), .rbyte(rbyte), .error(error)
   );

   typedef struct { logic [4:0] c; logic [7:0] b; logic [1:0] g; } cmd_t;
   typedef struct { logic [1:0] g; logic [1:0] st; int nwr; } done_t;

   cmd_t       exp_cmd[$];
   done_t      exp_done[$];
   logic [7:0] exp_rd[$];
   logic [7:0] rd_src[$];
   logic [7:0] wr_q[$];
   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // byte engine model: answers each command ENG_LAT cycles after it appears
   int         eng_cnt = 0;
   logic       eng_fired = 1'b0;
   logic [4:0] hold_mask = '0;
   logic       nack_en = 1'b0;
   logic [7:0] nack_val = 8'h00;

   always @(negedge clk) begin
      cdone = '0;
      rxack = 1'b0;
      if (!rst_n || cmds == '0) begin
         eng_cnt   = 0;
         eng_fired = 1'b0;
      end else if (!eng_fired) begin
         eng_cnt++;
         if (eng_cnt >= ENG_LAT && (cmds & hold_mask) == '0) begin
            eng_fired = 1'b1;
            cdone = cmds & 5'h0F;
            rxack = nack_en && cmds[1] && (tbyte == nack_val);
            if (cmds[2] && rd_src.size() > 0) rbyte = rd_src.pop_front();
         end
      end
   end

   // requesters drop req once their gnt bit is seen
   always @(negedge clk) req = req & ~gnt;

   // write-data source
   logic wr_pop = 1'b0;
   int   wr_cnt = 0;
   always @(negedge clk) begin
      if (wr_pop && wr_q.size() > 0) void'(wr_q.pop_front());
      wr_valid = (wr_q.size() > 0);
      wr_data  = wr_valid ? wr_q[0] : 8'h00;
      #1;
      wr_pop = wr_ready;
      if (wr_ready) wr_cnt++;
   end

   cmd_t       mon_c;
   done_t      mon_d;
   logic [7:0] mon_r;
   logic [4:0] prev_cmds = '0;

   always @(negedge clk) begin
      if (rst_n && cmds != '0 && prev_cmds == '0) begin
         chk("cmd_expected", exp_cmd.size() != 0, 1'b1);
         chk("gnt_onehot", $onehot0(gnt), 1'b1);
         if (exp_cmd.size() != 0) begin
            mon_c = exp_cmd.pop_front();
            chk("cmd_bits", cmds, mon_c.c);
            chk("cmd_gnt", gnt, mon_c.g);
            if (mon_c.c[1]) chk("cmd_tbyte", tbyte, mon_c.b);
         end
      end
      prev_cmds = rst_n ? cmds : '0;
   end

   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         chk("rd_expected", exp_rd.size() != 0, 1'b1);
         if (exp_rd.size() != 0) begin
            mon_r = exp_rd.pop_front();
            chk("rd_data", rd_data, mon_r);
         end
      end
   end

   always @(negedge clk) begin
      if (done === 1'b1) begin
         chk("done_expected", exp_done.size() != 0, 1'b1);
         if (exp_done.size() != 0) begin
            mon_d = exp_done.pop_front();
            chk("done_gnt", gnt, mon_d.g);
            chk("done_status", status, mon_d.st);
            chk("done_wr_ready_count", wr_cnt, mon_d.nwr);
         end
         wr_cnt = 0;
      end
   end

   task automatic pc(input logic [4:0] c, input logic [7:0] b, input logic [1:0] g);
      cmd_t e;
      e.c = c; e.b = b; e.g = g;
      exp_cmd.push_back(e);
   endtask

   task automatic ph(input logic [1:0] g, input logic [6:0] dev, input logic [7:0] rg);
      pc(C_ST, 8'h00, g);
      pc(C_WR, {dev, 1'b0}, g);
      pc(C_WR, rg, g);
   endtask

   task automatic pd(input logic [1:0] g, input logic [1:0] st, input int nwr);
      done_t e;
      e.g = g; e.st = st; e.nwr = nwr;
      exp_done.push_back(e);
   endtask

   task automatic req_txn(input int r, input logic rd, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [3:0] len);
      req_rd[r] = rd;
      if (r == 0) begin
         req_dev[6:0] = dev; req_reg[7:0] = rg; req_len[3:0] = len;
      end else begin
         req_dev[13:7] = dev; req_reg[15:8] = rg; req_len[7:4] = len;
      end
      req[r] = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, done, 1'b1);
      @(negedge clk);
   endtask

   int n;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs", {gnt, wr_ready, rd_data, rd_valid, done, status, cmds, tbyte}, 28'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // contention from reset: req0 first, then req1, then req0 again
      ph(2'b01, 7'h21, 8'h02); pc(C_WR, 8'h5A, 2'b01); pc(C_SP, 8'h00, 2'b01); pd(2'b01, 2'd0, 1);
      ph(2'b10, 7'h33, 8'h44); pc(C_ST, 8'h00, 2'b10); pc(C_WR, 8'h67, 2'b10);
      pc(C_RD, 8'h00, 2'b10); pc(C_RD | C_TX, 8'h00, 2'b10); pc(C_SP, 8'h00, 2'b10);
      pd(2'b10, 2'd0, 0);
      rd_src.push_back(8'h10); rd_src.push_back(8'h20);
      exp_rd.push_back(8'h10); exp_rd.push_back(8'h20);
      wr_q.push_back(8'h5A);
      req_txn(1, 1'b1, 7'h33, 8'h44, 4'd1);
      req_txn(0, 1'b0, 7'h21, 8'h02, 4'd0);
      wait_done("cont_req0_done", 200);
      n = 0;
      while (gnt !== 2'b10 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cont_req1_granted", gnt, 2'b10);
      ph(2'b01, 7'h22, 8'h03); pc(C_WR, 8'h6B, 2'b01); pc(C_SP, 8'h00, 2'b01); pd(2'b01, 2'd0, 1);
      wr_q.push_back(8'h6B);
      req_txn(0, 1'b0, 7'h22, 8'h03, 4'd0);
      wait_done("cont_req1_done", 200);
      wait_done("cont_req0b_done", 200);

      // two-byte write with write-data stall longer than the timeout
      ph(2'b01, 7'h50, 8'h10); pc(C_WR, 8'hA5, 2'b01); pc(C_WR, 8'h3C, 2'b01);
      pc(C_SP, 8'h00, 2'b01); pd(2'b01, 2'd0, 2);
      wr_q.push_back(8'hA5);
      req_txn(0, 1'b0, 7'h50, 8'h10, 4'd1);
      repeat (50) @(negedge clk);
      chk("stall_cmds_idle", cmds, 5'h00);
      chk("stall_gnt_held", gnt, 2'b01);
      wr_q.push_back(8'h3C);
      wait_done("wr2_done", 200);

      // single-byte read by req1
      ph(2'b10, 7'h68, 8'h75); pc(C_ST, 8'h00, 2'b10); pc(C_WR, 8'hD1, 2'b10);
      pc(C_RD | C_TX, 8'h00, 2'b10); pc(C_SP, 8'h00, 2'b10); pd(2'b10, 2'd0, 0);
      rd_src.push_back(8'h71); exp_rd.push_back(8'h71);
      req_txn(1, 1'b1, 7'h68, 8'h75, 4'd0);
      wait_done("rd1_done", 200);

      // address NACK
      nack_en = 1'b1; nack_val = 8'hA0;
      pc(C_ST, 8'h00, 2'b01); pc(C_WR, 8'hA0, 2'b01); pc(C_SP, 8'h00, 2'b01); pd(2'b01, 2'd1, 0);
      wr_q.push_back(8'h99);
      req_txn(0, 1'b0, 7'h50, 8'h10, 4'd0);
      wait_done("nack_done", 200);
      repeat (3) @(negedge clk);
      chk("status_hold", status, 2'd1);
      nack_en = 1'b0;
      wr_q.delete();
      @(negedge clk);

      // bus error during the second data write
      ph(2'b01, 7'h50, 8'h10); pc(C_WR, 8'h11, 2'b01); pc(C_WR, 8'h22, 2'b01); pd(2'b01, 2'd2, 2);
      wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33);
      req_txn(0, 1'b0, 7'h50, 8'h10, 4'd2);
      n = 0;
      while (!(cmds === C_WR && tbyte === 8'h22) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("err_reached_write2", tbyte, 8'h22);
      error = 1'b1;
      @(negedge clk);
      error = 1'b0;
      chk("err_cmds_off", cmds, 5'h00);
      chk("err_done", done, 1'b1);
      @(negedge clk);
      wr_q.delete();
      repeat (2) @(negedge clk);

      // timeout on START: cmds held exactly TIMEOUT cycles
      hold_mask = C_ST;
      pc(C_ST, 8'h00, 2'b01); pd(2'b01, 2'd3, 0);
      req_txn(0, 1'b0, 7'h50, 8'h10, 4'd0);
      n = 0;
      while (cmds === 5'h00 && n < 50) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (cmds !== 5'h00 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_cycles", n, 20);
      chk("tmo_done", done, 1'b1);
      @(negedge clk);

      // timeout on STOP
      hold_mask = C_SP;
      ph(2'b10, 7'h11, 8'h22); pc(C_WR, 8'h33, 2'b10); pc(C_SP, 8'h00, 2'b10); pd(2'b10, 2'd3, 1);
      wr_q.push_back(8'h33);
      req_txn(1, 1'b0, 7'h11, 8'h22, 4'd0);
      wait_done("tmo_stop_done", 300);
      hold_mask = '0;

      // reset in the middle of a four-byte read
      ph(2'b10, 7'h68, 8'h75); pc(C_ST, 8'h00, 2'b10); pc(C_WR, 8'hD1, 2'b10);
      pc(C_RD, 8'h00, 2'b10); pc(C_RD, 8'h00, 2'b10);
      for (int i = 1; i <= 4; i++) begin
         rd_src.push_back(8'(i));
         exp_rd.push_back(8'(i));
      end
      req_txn(1, 1'b1, 7'h68, 8'h75, 4'd3);
      n = 0;
      while (rd_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_first_rd", rd_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", {gnt, wr_ready, rd_data, rd_valid, done, status, cmds, tbyte}, 28'h0);
      exp_cmd.delete(); exp_rd.delete(); rd_src.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wr_cnt = 0;
      @(negedge clk);
      ph(2'b01, 7'h50, 8'h10); pc(C_WR, 8'hC3, 2'b01); pc(C_SP, 8'h00, 2'b01); pd(2'b01, 2'd0, 1);
      wr_q.push_back(8'hC3);
      req_txn(0, 1'b0, 7'h50, 8'h10, 4'd0);
      wait_done("post_rst_done", 200);
      repeat (3) @(negedge clk);

      chk("cmd_queue_empty", exp_cmd.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);
      chk("rd_queue_empty", exp_rd.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/i2cm_seq.md
Name: i2cm_seq

Overview:
Transaction-level sequencer that sits in front of the I2C master byte engine (its cmds/tbyte/cdone/rxack/rbyte/error interface). It accepts register-style I2C write and read transactions from two requesters and arbitrates between them round-robin. It expands each transaction into the START / WRITE / READ / STOP byte-command sequence and returns read data and a completion status to the owning requester.

Parameters:
TIMEOUT, 65535, max clk cycles waiting for cdone on any single command before abort (16-bit counter)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  2  per-requester transaction request; held high until the matching gnt bit is seen
req_rd  in  2  per requester: 1 = read transaction, 0 = write transaction
req_dev  in  14  {dev1[6:0], dev0[6:0]} 7-bit slave addresses
req_reg  in  16  {reg1[7:0], reg0[7:0]} register sub-address
req_len  in  8  {len1[3:0], len0[3:0]} byte count minus 1 (1..16 bytes)
gnt  out  2  one-hot owner of the sequencer; 0 when idle
wr_data  in  8  write byte from the granted requester
wr_valid  in  1  wr_data valid
wr_ready  out  1  wr_data consumed this cycle
rd_data  out  8  read byte
rd_valid  out  1  one-cycle pulse per read byte
done  out  1  one-cycle pulse at transaction end; gnt is still valid in that cycle
status  out  2  valid with done: 0 OK, 1 NACK, 2 bus error, 3 timeout
cmds  out  5  to byte engine: bit0 START, bit1 WRITE, bit2 READ, bit3 STOP, bit4 TXACK (send NACK)
tbyte  out  8  byte to transmit, valid while cmds[1] is set
cdone  in  5  engine completion pulse, same bit encoding as cmds
rxack  in  1  ACK bit sampled on the last WRITE (1 = NACK), valid in the cdone cycle
rbyte  in  8  received byte, valid in the cdone[2] cycle
error  in  1  engine bus error (arbitration loss or illegal bus state)

Behaviour:
- Reset values: all outputs 0; arbiter pointer selects requester 0 first.
- Reset mid-transaction: everything returns to IDLE immediately. No STOP is issued and no done pulse is produced.
- Arbitration (state IDLE):
  - When any req bit is high, grant round-robin. Priority goes to the requester not granted last; if only one is requesting, it wins.
  - gnt is registered one cycle after req is seen, and the request fields are latched in that same cycle.
  - gnt stays constant until the cycle after done; IDLE is re-entered in that following cycle.
- Command handshake:
  - Drive exactly one cmd bit (plus TXACK where specified) and hold it until the matching cdone bit arrives.
  - Register cmds = 0 in the cycle after cdone, which is the cycle the engine re-enters IDLE. Never reissue before that.
  - Minimum gap between commands: 1 cycle with cmds = 0.
- Write sequence: START; WRITE {dev,0}; WRITE reg; WRITE data x (len+1); STOP.
- Read sequence: START; WRITE {dev,0}; WRITE reg; START (repeated); WRITE {dev,1}; READ x (len+1); STOP.
  - TXACK is set only on the last READ. All other reads send ACK.
- States: IDLE, GRANT, START, DEVW, REGA, WDATA, RSTART, DEVR, RDATA, STOP, DONE. A byte counter (4-bit) counts down from len.
- WDATA:
  - wr_ready pulses for 1 cycle when wr_valid = 1 and the sequencer is ready to issue the next WRITE. The byte is latched into tbyte.
  - If wr_valid = 0, the sequencer stalls with cmds = 0. No timeout applies while waiting for write data.
- RDATA: on each cdone[2], present rd_data = rbyte with rd_valid = 1 in the following cycle.
- NACK: rxack = 1 on any WRITE skips the remaining bytes, issues STOP, then done with status 1.
- Bus error: error = 1 at any time while busy forces cmds = 0 on the next cycle, skips STOP, and goes to done with status 2.
  - Error has priority over cdone in the same cycle.
- Timeout:
  - The counter resets on each command issue and counts while waiting for cdone.
  - When it reaches TIMEOUT: cmds = 0, skip STOP, done with status 3.
  - A timeout waiting on STOP also gives status 3.
- Status priority in the same cycle: error > timeout > NACK.
- done pulses exactly once per grant; status holds until the next done.

Test Plan:
- Write, req0, dev 0x50, reg 0x10, len 1 (2 bytes 0xA5, 0x3C), all ACK -> cmds sequence START, W 0xA0, W 0x10, W 0xA5, W 0x3C, STOP; 2 wr_ready pulses; done with status 0; gnt = 01 throughout.
- Read, req1, dev 0x68, reg 0x75, len 0; engine returns 0x71 -> START, W 0xD0, W 0x75, START, W 0xD1, READ with TXACK = 1, STOP; one rd_valid with rd_data 0x71; done with status 0.
- Address NACK: rxack = 1 on W 0xA0 -> next command is STOP; no wr_ready; done with status 1.
- Contention: req = 11 from reset -> req0 served first, then req1. With req0 re-asserted during req1's transaction, req0 is served after req1. No overlap of gnt bits.
- error pulses during the 2nd data WRITE -> cmds = 0 next cycle, no STOP, done with status 2. TIMEOUT = 20 with cdone withheld -> done with status 3 after 20 cycles.
- rst_n asserted mid read -> all outputs 0 immediately; next req is granted cleanly with a fresh START.
